// File: rtl/dpll_acq_ctrl_if.sv
// Acquisition controller bundle: enable, PD decisions and DCO code in; load, gains and status out.
// Latency: none, wires only.
// Backpressure: none; every signal is driven and sampled on every clk_ref cycle.
interface dpll_acq_ctrl_if #(
    parameter int CODE_W = 13
);
    // Controls and monitors flowing into the sequencer
    logic              enable;
    logic              pd_up;
    logic              pd_dn;
    logic              pd_valid;
    logic [CODE_W-1:0] dco_code;

    // Commands and status flowing out of the sequencer
    logic              dco_load;
    logic [CODE_W-1:0] dco_init;
    logic [2:0]        kp_sel;
    logic [2:0]        ki_sel;
    logic              locked;
    logic              lock_lost;
    logic [2:0]        state;

    // Sequencer side
    modport master (
        input  enable, pd_up, pd_dn, pd_valid, dco_code,
        output dco_load, dco_init, kp_sel, ki_sel, locked, lock_lost, state
    );

    // Loop-filter / DCO side
    modport slave (
        output enable, pd_up, pd_dn, pd_valid, dco_code,
        input  dco_load, dco_init, kp_sel, ki_sel, locked, lock_lost, state
    );
endinterface

// File: rtl/dpll_acq_ctrl.sv
// DPLL acquisition sequencer: preload DCO, coarse->fine gain shift, dither-based lock, re-acquire.
// Latency: every output is registered; a condition seen on one edge shows on the outputs after it.
// Backpressure: none; a PD decision is consumed whenever pd_valid is high with exactly one sign.
module dpll_acq_ctrl #(
    parameter int                CODE_W     = 13,
    parameter logic [CODE_W-1:0] INIT_CODE  = 13'h1000,
    parameter int                COARSE_CYC = 256,
    parameter int                LOCK_CNT   = 1024,
    parameter int                MAX_RUN    = 4,
    parameter int                UNLOCK_RUN = 16,
    parameter logic [2:0]        KP_COARSE  = 3'd6,
    parameter logic [2:0]        KI_COARSE  = 3'd5,
    parameter logic [2:0]        KP_FINE    = 3'd3,
    parameter logic [2:0]        KI_FINE    = 3'd1
) (
    input  logic            clk_ref,
    input  logic            reset,
    dpll_acq_ctrl_if.master io
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        COARSE = 3'd2,
        FINE   = 3'd3,
        LOCKED = 3'd4
    } state_t;

    // Timer only has to reach COARSE_CYC-1 before the state moves on
    localparam int TMR_W = (COARSE_CYC > 1) ? $clog2(COARSE_CYC) : 1;
    localparam int RUN_W = 5;

    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(COARSE_CYC - 1);
    localparam logic [RUN_W-1:0] RUN_SAT    = '1;
    localparam logic [RUN_W-1:0] MAX_RUN_L  = RUN_W'(MAX_RUN);
    localparam logic [RUN_W-1:0] UNLOCK_L   = RUN_W'(UNLOCK_RUN);
    localparam logic [16:0]      LOCK_TGT   = 17'(LOCK_CNT);

    state_t            cur_state;
    logic [TMR_W-1:0]  timer;
    logic [RUN_W-1:0]  run_len;
    logic              last_sign;
    logic [15:0]       lock_cnt;

    logic              dco_load_r;
    logic [CODE_W-1:0] dco_init_r;
    logic [2:0]        kp_r;
    logic [2:0]        ki_r;
    logic              locked_r;
    logic              lock_lost_r;

    logic              decision;
    logic              sign;
    logic              sat;
    logic [RUN_W-1:0]  run_next;
    logic [16:0]       lock_next;

    // Decode the PD decision, DCO rail detection and the run length this decision would give
    always_comb begin
        decision  = io.pd_valid & (io.pd_up ^ io.pd_dn);
        sign      = io.pd_up;
        sat       = (~|io.dco_code) | (&io.dco_code);
        run_next  = run_len;
        if (decision) begin
            // run_len==0 means no decision seen since the last clear, so this one starts a run
            if ((run_len == '0) || (sign != last_sign)) begin
                run_next = RUN_W'(1);
            end else if (run_len != RUN_SAT) begin
                run_next = run_len + 1'b1;
            end
        end
        lock_next = {1'b0, lock_cnt} + 17'd1;
    end

    // Sequencer FSM with all outputs registered alongside the state
    always_ff @(posedge clk_ref) begin
        if (reset || !io.enable) begin
            cur_state   <= IDLE;
            timer       <= '0;
            run_len     <= '0;
            last_sign   <= 1'b0;
            lock_cnt    <= '0;
            dco_load_r  <= 1'b0;
            dco_init_r  <= INIT_CODE;
            kp_r        <= KP_COARSE;
            ki_r        <= KI_COARSE;
            locked_r    <= 1'b0;
            lock_lost_r <= 1'b0;
        end else begin
            dco_load_r  <= 1'b0;
            lock_lost_r <= 1'b0;
            dco_init_r  <= INIT_CODE;
            case (cur_state)
                IDLE: begin
                    cur_state  <= LOAD;
                    dco_load_r <= 1'b1;
                end

                LOAD: begin
                    cur_state <= COARSE;
                    timer     <= '0;
                    run_len   <= '0;
                    kp_r      <= KP_COARSE;
                    ki_r      <= KI_COARSE;
                end

                COARSE: begin
                    if (timer == TMR_LAST) begin
                        cur_state <= FINE;
                        run_len   <= '0;
                        lock_cnt  <= '0;
                        kp_r      <= KP_FINE;
                        ki_r      <= KI_FINE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                FINE, LOCKED: begin
                    if (sat) begin
                        // DCO pinned at a rail: re-centre it; this is not a lock loss
                        cur_state  <= LOAD;
                        dco_load_r <= 1'b1;
                        locked_r   <= 1'b0;
                        run_len    <= '0;
                        lock_cnt   <= '0;
                        kp_r       <= KP_COARSE;
                        ki_r       <= KI_COARSE;
                    end else if (decision) begin
                        run_len   <= run_next;
                        last_sign <= sign;
                        if (cur_state == FINE) begin
                            // A long same-sign run means we are still slewing: restart qualification
                            if (run_next > MAX_RUN_L) begin
                                lock_cnt <= '0;
                            end else if (lock_next == LOCK_TGT) begin
                                cur_state <= LOCKED;
                                locked_r  <= 1'b1;
                                lock_cnt  <= '0;
                            end else begin
                                lock_cnt <= lock_next[15:0];
                            end
                        end else if (run_next >= UNLOCK_L) begin
                            // Phase walked off: redo coarse slewing around the current code
                            cur_state   <= COARSE;
                            lock_lost_r <= 1'b1;
                            locked_r    <= 1'b0;
                            timer       <= '0;
                            run_len     <= '0;
                            kp_r        <= KP_COARSE;
                            ki_r        <= KI_COARSE;
                        end
                    end
                end

                default: begin
                    cur_state <= IDLE;
                end
            endcase
        end
    end

    assign io.dco_load  = dco_load_r;
    assign io.dco_init  = dco_init_r;
    assign io.kp_sel    = kp_r;
    assign io.ki_sel    = ki_r;
    assign io.locked    = locked_r;
    assign io.lock_lost = lock_lost_r;
    assign io.state     = cur_state;

    // The load pulse, lock flag and loss pulse are only ever seen in their own states
    a_load_in_load : assert property (@(posedge clk_ref) disable iff (reset)
        dco_load_r |-> (cur_state == LOAD));
    a_locked_state : assert property (@(posedge clk_ref) disable iff (reset)
        locked_r == (cur_state == LOCKED));
    a_lost_coarse  : assert property (@(posedge clk_ref) disable iff (reset)
        lock_lost_r |-> (cur_state == COARSE));

endmodule

// File: tb/tb_dpll_acq_ctrl.sv
module tb_dpll_acq_ctrl;

    localparam int CODE_W     = 13;
    localparam int COARSE_CYC = 256;
    localparam int LOCK_CNT   = 1024;
    localparam int MAX_RUN    = 4;
    localparam int UNLOCK_RUN = 16;
    localparam logic [24:0] RESET_VEC = {1'b0, 13'h1000, 3'd6, 3'd5, 1'b0, 1'b0, 3'd0};

    logic clk_ref = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_ref = ~clk_ref;

    dpll_acq_ctrl_if #(.CODE_W(CODE_W)) bus ();

    dpll_acq_ctrl #(.CODE_W(CODE_W)) dut (
        .clk_ref (clk_ref),
        .reset   (reset),
        .io      (bus)
    );

    logic [24:0] dut_vec;
    assign dut_vec = {bus.dco_load, bus.dco_init, bus.kp_sel, bus.ki_sel,
                      bus.locked, bus.lock_lost, bus.state};

    // Reference model: state number, cycles spent in COARSE, qualifying decisions in FINE,
    // and the sign history of decisions since the last run clear
    int m_state = 0;
    int m_timer = 0;
    int m_good  = 0;
    bit m_lost  = 0;
    bit m_hist[$];

    function automatic int trailing_run();
        int n = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] != m_hist[m_hist.size() - 1]) break;
            n++;
        end
        return (n > 31) ? 31 : n;
    endfunction

    function automatic void model_step();
        bit dv;
        bit sat;
        m_lost = 0;
        if (reset || !bus.enable) begin
            m_state = 0; m_timer = 0; m_good = 0; m_hist.delete();
            return;
        end
        dv  = bus.pd_valid && (bus.pd_up != bus.pd_dn);
        sat = (bus.dco_code == 13'h0000) || (bus.dco_code == 13'h1FFF);
        case (m_state)
            0: m_state = 1;
            1: begin m_state = 2; m_timer = 0; m_hist.delete(); end
            2: begin
                m_timer++;
                if (m_timer == COARSE_CYC) begin m_state = 3; m_good = 0; m_hist.delete(); end
            end
            3: begin
                if (sat) begin m_state = 1; m_good = 0; m_hist.delete(); end
                else if (dv) begin
                    m_hist.push_back(bus.pd_up);
                    if (trailing_run() > MAX_RUN) m_good = 0;
                    else m_good++;
                    if (m_good == LOCK_CNT) m_state = 4;
                end
            end
            4: begin
                if (sat) begin m_state = 1; m_hist.delete(); end
                else if (dv) begin
                    m_hist.push_back(bus.pd_up);
                    if (trailing_run() >= UNLOCK_RUN) begin
                        m_state = 2; m_lost = 1; m_timer = 0; m_hist.delete();
                    end
                end
            end
            default: m_state = 0;
        endcase
        if (m_hist.size() > 40) void'(m_hist.pop_front());
    endfunction

    function automatic logic [24:0] exp_vec();
        logic fine;
        fine = (m_state == 3) || (m_state == 4);
        return {(m_state == 1), 13'h1000, fine ? 3'd3 : 3'd6, fine ? 3'd1 : 3'd5,
                (m_state == 4), m_lost, 3'(m_state)};
    endfunction

    task automatic cyc();
        @(posedge clk_ref);
        model_step();
        #1;
    endtask

    // Optional ignored cycles (both/neither sign, or not valid), then one valid decision
    task automatic send(input bit up, input bit gaps);
        if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            for (int i = 0; i < g; i++) begin
                int k;
                k = $urandom_range(0, 2);
                bus.pd_valid = (k != 2);
                bus.pd_up    = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : 1'($urandom_range(0, 1));
                bus.pd_dn    = (k == 2) ? !bus.pd_up : bus.pd_up;
                bus.dco_code = 13'($urandom_range(1, 13'h1FFE));
                cyc();
            end
        end
        bus.pd_valid = 1'b1;
        bus.pd_up    = up;
        bus.pd_dn    = !up;
        bus.dco_code = 13'($urandom_range(1, 13'h1FFE));
        cyc();
        bus.pd_valid = 1'b0;
    endtask

    task automatic goto_fine();
        bus.enable = 1'b0; bus.pd_valid = 1'b0; bus.dco_code = 13'h0800; reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0; bus.enable = 1'b1;
        repeat (2 + COARSE_CYC) cyc();
    endtask

    task automatic goto_locked();
        goto_fine();
        for (int i = 0; i < 1100 && bus.locked !== 1'b1; i++) send(i % 2 == 0, 1'b0);
        send(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.enable = 1'b0; bus.pd_valid = 1'b0; bus.pd_up = 1'b0;
        bus.pd_dn = 1'b0; bus.dco_code = 13'h0800;
        repeat (3) cyc();
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++; $display("FAIL reset_values: got %h want %h", dut_vec, RESET_VEC);
        end
        reset = 1'b0; bus.enable = 1'b1;
        cyc();
        checks++;
        if ({bus.dco_load, bus.state} !== {1'b1, 3'd1}) begin
            errors++; $display("FAIL reset_load: got load=%b state=%0d want load=1 state=1", bus.dco_load, bus.state);
        end
        checks++;
        if (bus.dco_init !== 13'h1000) begin
            errors++; $display("FAIL reset_init: got %h want 1000", bus.dco_init);
        end
        cyc();
        checks++;
        if ({bus.dco_load, bus.state} !== {1'b0, 3'd2}) begin
            errors++; $display("FAIL reset_coarse: got load=%b state=%0d want load=0 state=2", bus.dco_load, bus.state);
        end
        begin
            int pulses = 0;
            for (int i = 0; i < 20; i++) begin cyc(); if (bus.dco_load === 1'b1) pulses++; end
            checks++;
            if (pulses != 0) begin
                errors++; $display("FAIL reset_single_load: got %0d extra pulses want 0", pulses);
            end
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL reset_model: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_acquire();
        int n = 0;
        int d = 0;
        bit up = 1'b1;
        reset = 1'b1; bus.enable = 1'b0; bus.pd_valid = 1'b0;
        repeat (3) cyc();
        reset = 1'b0; bus.enable = 1'b1;
        while (bus.state !== 3'd3 && n < 400) begin
            bus.pd_valid = 1'b1; bus.pd_up = up; bus.pd_dn = !up; up = !up;
            cyc(); n++;
            if (n == 100) begin
                checks++;
                if ({bus.kp_sel, bus.ki_sel} !== {3'd6, 3'd5}) begin
                    errors++; $display("FAIL acq_coarse_gain: got %0d/%0d want 6/5", bus.kp_sel, bus.ki_sel);
                end
            end
        end
        checks++;
        if (n != 2 + COARSE_CYC) begin
            errors++; $display("FAIL acq_fine_cycle: got %0d want %0d", n, 2 + COARSE_CYC);
        end
        checks++;
        if ({bus.kp_sel, bus.ki_sel} !== {3'd3, 3'd1}) begin
            errors++; $display("FAIL acq_fine_gain: got %0d/%0d want 3/1", bus.kp_sel, bus.ki_sel);
        end
        while (bus.locked !== 1'b1 && d < 1100) begin
            send(up, 1'b0); up = !up; d++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL acq_model: got %h want %h", dut_vec, exp_vec());
            end
        end
        checks++;
        if (d != LOCK_CNT) begin
            errors++; $display("FAIL acq_lock_count: got %0d want %0d", d, LOCK_CNT);
        end
        checks++;
        if ({bus.state, bus.kp_sel, bus.ki_sel} !== {3'd4, 3'd3, 3'd1}) begin
            errors++; $display("FAIL acq_locked_state: got st=%0d kp=%0d ki=%0d want 4/3/1", bus.state, bus.kp_sel, bus.ki_sel);
        end
    endtask

    task automatic test_long_run();
        for (int pass = 0; pass < 2; pass++) begin
            int cnt = 0;
            int ups = (pass == 0) ? 5 : 4;
            int want = (pass == 0) ? LOCK_CNT : LOCK_CNT - 500 - 4;
            goto_fine();
            for (int i = 0; i < 500; i++) send(i % 2 == 0, 1'b1);
            for (int i = 0; i < ups; i++) send(1'b1, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL run_model_inject: got %h want %h", dut_vec, exp_vec());
            end
            for (int i = 0; i < 1100 && bus.locked !== 1'b1; i++) begin
                send(i % 2 != 0, 1'b1); cnt++;
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL run_model: got %h want %h", dut_vec, exp_vec());
                end
            end
            checks++;
            if (cnt != want) begin
                errors++; $display("FAIL run_relock_%0d: got %0d decisions want %0d", ups, cnt, want);
            end
        end
    endtask

    task automatic test_unlock();
        goto_locked();
        checks++;
        if (bus.state !== 3'd4) begin
            errors++; $display("FAIL unlock_pre: got state %0d want 4", bus.state);
        end
        for (int i = 0; i < UNLOCK_RUN - 1; i++) begin
            send(1'b1, 1'b1);
            checks++;
            if ({bus.locked, bus.lock_lost, bus.state} !== {1'b1, 1'b0, 3'd4}) begin
                errors++; $display("FAIL unlock_early: got lk=%b lost=%b st=%0d want 1/0/4", bus.locked, bus.lock_lost, bus.state);
            end
        end
        send(1'b1, 1'b1);
        checks++;
        if ({bus.lock_lost, bus.locked, bus.state, bus.dco_load} !== {1'b1, 1'b0, 3'd2, 1'b0}) begin
            errors++; $display("FAIL unlock_pulse: got lost=%b lk=%b st=%0d ld=%b want 1/0/2/0", bus.lock_lost, bus.locked, bus.state, bus.dco_load);
        end
        cyc();
        checks++;
        if ({bus.lock_lost, bus.state, bus.dco_load, bus.kp_sel, bus.ki_sel} !== {1'b0, 3'd2, 1'b0, 3'd6, 3'd5}) begin
            errors++; $display("FAIL unlock_after: got %h want lost=0 st=2 ld=0 6/5", {bus.lock_lost, bus.state, bus.dco_load, bus.kp_sel, bus.ki_sel});
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL unlock_model: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_saturation();
        goto_locked();
        bus.pd_valid = 1'b0; bus.dco_code = 13'h1FFF;
        cyc();
        checks++;
        if ({bus.state, bus.dco_load, bus.locked, bus.lock_lost} !== {3'd1, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sat_locked: got st=%0d ld=%b lk=%b lost=%b want 1/1/0/0", bus.state, bus.dco_load, bus.locked, bus.lock_lost);
        end
        bus.dco_code = 13'h0800;
        cyc();
        checks++;
        if ({bus.state, bus.dco_load} !== {3'd2, 1'b0}) begin
            errors++; $display("FAIL sat_recoarse: got st=%0d ld=%b want 2/0", bus.state, bus.dco_load);
        end
        bus.dco_code = 13'h0000;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (bus.state !== 3'd2) begin
                errors++; $display("FAIL sat_coarse_ignored: got state %0d want 2", bus.state);
            end
        end
        bus.dco_code = 13'h0800;
        repeat (COARSE_CYC - 5) cyc();
        checks++;
        if (bus.state !== 3'd3) begin
            errors++; $display("FAIL sat_fine_again: got state %0d want 3", bus.state);
        end
        bus.dco_code = 13'h0000;
        cyc();
        checks++;
        if ({bus.state, bus.dco_load, bus.lock_lost} !== {3'd1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL sat_fine_zero: got st=%0d ld=%b lost=%b want 1/1/0", bus.state, bus.dco_load, bus.lock_lost);
        end
        bus.dco_code = 13'h0800;
        cyc();
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL sat_model: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_ignore_disable();
        int cnt = 0;
        goto_fine();
        for (int i = 0; i < 100; i++) send(i % 2 == 0, 1'b1);
        checks++;
        if (bus.state !== 3'd3) begin
            errors++; $display("FAIL dis_pre: got state %0d want 3", bus.state);
        end
        bus.enable = 1'b0;
        cyc();
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++; $display("FAIL dis_idle: got %h want %h", dut_vec, RESET_VEC);
        end
        bus.enable = 1'b1;
        cyc();
        checks++;
        if ({bus.state, bus.dco_load} !== {3'd1, 1'b1}) begin
            errors++; $display("FAIL dis_reload: got st=%0d ld=%b want 1/1", bus.state, bus.dco_load);
        end
        repeat (1 + COARSE_CYC) cyc();
        checks++;
        if (bus.state !== 3'd3) begin
            errors++; $display("FAIL dis_fine: got state %0d want 3", bus.state);
        end
        for (int i = 0; i < 1100 && bus.locked !== 1'b1; i++) begin
            send(i % 2 == 0, 1'b1); cnt++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL ign_model: got %h want %h", dut_vec, exp_vec());
            end
        end
        checks++;
        if (cnt != LOCK_CNT) begin
            errors++; $display("FAIL ign_lock_count: got %0d want %0d", cnt, LOCK_CNT);
        end
    endtask

    task automatic test_random();
        int burst = 0;
        bit sgn = 1'b0;
        reset = 1'b1; bus.enable = 1'b0; bus.pd_valid = 1'b0;
        repeat (2) cyc();
        reset = 1'b0; bus.enable = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            int r;
            r = $urandom_range(0, 9999);
            bus.enable = (r >= 3);
            reset = (r == 9999);
            if (r >= 4 && r < 6) bus.dco_code = ($urandom_range(0, 1) == 1) ? 13'h1FFF : 13'h0000;
            else bus.dco_code = 13'($urandom_range(1, 13'h1FFE));
            if (burst == 0 && r >= 10 && r < 12) burst = $urandom_range(5, 20);
            if ($urandom_range(0, 9) < 8) begin
                if (burst > 0) burst--;
                else if ($urandom_range(0, 9) != 0) sgn = !sgn;
                bus.pd_valid = 1'b1; bus.pd_up = sgn; bus.pd_dn = !sgn;
            end else begin
                bus.pd_valid = 1'($urandom_range(0, 1));
                bus.pd_up = 1'($urandom_range(0, 1));
                bus.pd_dn = bus.pd_valid ? bus.pd_up : !bus.pd_up;
            end
            cyc();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL rand_model: cycle %0d got %h want %h", c, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time budget expired, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0; bus.pd_valid = 1'b0; bus.pd_up = 1'b0; bus.pd_dn = 1'b0;
        bus.dco_code = 13'h0800;
        test_reset();
        test_acquire();
        test_long_run();
        test_unlock();
        test_saturation();
        test_ignore_disable();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
